// File: rtl/immediate_decode_stage_pkg.sv
// Shared constants for the immediate decode stage: type codes, base opcodes,
// RVC quadrant/funct3 encodings and skid-buffer occupancy states.
package immediate_decode_stage_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } imm_type_e;

    // opcode[6:2] of 32-bit encodings
    localparam logic [4:0] OPC_LOAD       = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM   = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM     = 5'b00100;
    localparam logic [4:0] OPC_AUIPC      = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32  = 5'b00110;
    localparam logic [4:0] OPC_STORE      = 5'b01000;
    localparam logic [4:0] OPC_OP         = 5'b01100;
    localparam logic [4:0] OPC_LUI        = 5'b01101;
    localparam logic [4:0] OPC_OP_32      = 5'b01110;
    localparam logic [4:0] OPC_BRANCH     = 5'b11000;
    localparam logic [4:0] OPC_JALR       = 5'b11001;
    localparam logic [4:0] OPC_JAL        = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM     = 5'b11100;

    localparam logic [1:0] RVC_Q0 = 2'b00;
    localparam logic [1:0] RVC_Q1 = 2'b01;
    localparam logic [1:0] RVC_Q2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_RSVD     = 3'b100;
    localparam logic [2:0] C0_SW       = 3'b110;
    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_SWSP     = 3'b110;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/immediate_decode_stage_core.sv
// Combinational immediate/type decoder for one 32-bit or 16-bit RVC instruction.
// Every immediate is pure bit selection plus sign/zero extension.
module imm_decode_core
    import immediate_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          ENABLE_RVC = 1'b1
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o,
    output logic            rvc_o,
    output logic            illegal_o
);

    logic [31:0] i;
    logic [15:0] c;
    logic [31:0] imm32;

    assign i = instr_i;
    assign c = instr_i[15:0];

    always_comb begin
        imm32     = '0;
        type_o    = R_TYPE;
        rvc_o     = 1'b0;
        illegal_o = 1'b0;

        if (i[1:0] == 2'b11) begin
            case (i[6:2])
                OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
                    type_o = I_TYPE;
                    imm32  = {{20{i[31]}}, i[31:20]};
                end
                OPC_OP_IMM_32: begin
                    if (XLEN == 64) begin
                        type_o = I_TYPE;
                        imm32  = {{20{i[31]}}, i[31:20]};
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                OPC_STORE: begin
                    type_o = S_TYPE;
                    imm32  = {{20{i[31]}}, i[31:25], i[11:7]};
                end
                OPC_BRANCH: begin
                    type_o = B_TYPE;
                    imm32  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    type_o = U_TYPE;
                    imm32  = {i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    type_o = J_TYPE;
                    imm32  = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                end
                OPC_OP, OPC_OP_32: type_o = R_TYPE;
                default:           illegal_o = 1'b1;
            endcase
        end else begin
            rvc_o = 1'b1;
            if (!ENABLE_RVC) begin
                illegal_o = 1'b1;
            end else begin
                case ({c[1:0], c[15:13]})
                    {RVC_Q0, C0_ADDI4SPN}: begin
                        if (c == 16'h0000) begin
                            illegal_o = 1'b1;
                        end else begin
                            type_o = I_TYPE;
                            imm32  = {22'b0, c[10:7], c[12:11], c[5], c[6], 2'b00};
                        end
                    end
                    {RVC_Q0, C0_LW}: begin
                        type_o = I_TYPE;
                        imm32  = {25'b0, c[5], c[12:10], c[6], 2'b00};
                    end
                    {RVC_Q0, C0_SW}: begin
                        type_o = S_TYPE;
                        imm32  = {25'b0, c[5], c[12:10], c[6], 2'b00};
                    end
                    {RVC_Q0, C0_RSVD}: illegal_o = 1'b1;
                    {RVC_Q1, C1_ADDI}, {RVC_Q1, C1_LI}: begin
                        type_o = I_TYPE;
                        imm32  = {{26{c[12]}}, c[12], c[6:2]};
                    end
                    {RVC_Q1, C1_LUI}: begin
                        // rd == x2 turns C.LUI's slot into C.ADDI16SP
                        if (c[11:7] == 5'd2) begin
                            type_o = I_TYPE;
                            imm32  = {{22{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0};
                        end else begin
                            type_o = U_TYPE;
                            imm32  = {{14{c[12]}}, c[12], c[6:2], 12'b0};
                        end
                    end
                    {RVC_Q1, C1_J}: begin
                        type_o = J_TYPE;
                        imm32  = {{20{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
                    end
                    {RVC_Q1, C1_JAL}: begin
                        if (XLEN == 32) begin
                            type_o = J_TYPE;
                            imm32  = {{20{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
                        end
                    end
                    {RVC_Q1, C1_BEQZ}, {RVC_Q1, C1_BNEZ}: begin
                        type_o = B_TYPE;
                        imm32  = {{23{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
                    end
                    {RVC_Q2, C2_LWSP}: begin
                        type_o = I_TYPE;
                        imm32  = {24'b0, c[3:2], c[12], c[6:4], 2'b00};
                    end
                    {RVC_Q2, C2_SWSP}: begin
                        type_o = S_TYPE;
                        imm32  = {24'b0, c[8:7], c[12:9], 2'b00};
                    end
                    default: type_o = R_TYPE;
                endcase
            end
        end

        if (illegal_o) begin
            imm32  = '0;
            type_o = R_TYPE;
        end
    end

    // zero-extended fields always have bit 31 clear, so one sign extension serves all
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate decode stage: decoder at the input feeding a 2-entry
// skid buffer with a valid/ready handshake on both sides.
module immediate_decode_stage
    import immediate_decode_stage_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter bit          ENABLE_RVC = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_rvc,
    output logic            out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
        logic            rvc;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{imm: '0, typ: R_TYPE, rvc: 1'b0, illegal: 1'b0};

    entry_t dec;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    occ_e   state_q, state_d;
    logic   ready_q, ready_d;
    logic   in_fire, out_fire;

    imm_decode_core #(
        .XLEN       (XLEN),
        .ENABLE_RVC (ENABLE_RVC)
    ) u_core (
        .instr_i   (in_instr),
        .imm_o     (dec.imm),
        .type_o    (dec.typ),
        .rvc_o     (dec.rvc),
        .illegal_o (dec.illegal)
    );

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_ready  = ready_q;
    assign in_fire   = in_valid && ready_q;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    main_d  = dec;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = dec;
                end else if (in_fire) begin
                    skid_d  = dec;
                    state_d = OCC_FULL;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only the drain case exists
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush) begin
            state_d = OCC_EMPTY;
        end
        ready_d = (state_d != OCC_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            ready_q <= 1'b1;
            main_q  <= ENTRY_RESET;
            skid_q  <= ENTRY_RESET;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_imm     = main_q.imm;
    assign out_type    = main_q.typ;
    assign out_rvc     = main_q.rvc;
    assign out_illegal = main_q.illegal;

endmodule
